// File: rtl/seq_mult_nxn.sv
// Digit-serial multiplier. One DIGIT x DIGIT partial product is added per clock.
// Signed operands are multiplied as magnitudes, and the result is negated when it completes.
module seq_mult_nxn #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               done_flag,
    output logic [2*WIDTH-1:0] product_out,
    output logic [1:0]         state_out
);
    // state | meaning
    // IDLE  | waiting for start; product_out holds the last result
    // CALC  | accumulating one digit-pair partial product per edge
    // DONE  | one-cycle result strobe, then back to IDLE
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;
    localparam int DPW   = 2 * DIGIT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((DIGIT < 2) || (WIDTH % DIGIT != 0) || (N < 1)) begin : g_bad_params
            $error("seq_mult_nxn: WIDTH must be a non-zero multiple of DIGIT, with DIGIT >= 2");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_res;
    logic [PW-1:0]    acc;
    logic [IDX_W-1:0] idx_i;
    logic [IDX_W-1:0] idx_j;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DPW-1:0]   digit_prod;
    int               shift_amt;
    logic [PW-1:0]    term;
    logic [PW-1:0]    acc_next;
    logic             last_pair;

    always_comb begin
        a_dig      = a_mag[idx_i*DIGIT +: DIGIT];
        b_dig      = b_mag[idx_j*DIGIT +: DIGIT];
        digit_prod = DPW'(a_dig) * DPW'(b_dig);
        shift_amt  = (int'(idx_i) + int'(idx_j)) * DIGIT;
        term       = PW'(digit_prod) << shift_amt;
        acc_next   = acc + term;
        last_pair  = (idx_i == LAST_IDX) && (idx_j == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= IDLE;
            a_mag       <= '0;
            b_mag       <= '0;
            neg_res     <= 1'b0;
            acc         <= '0;
            idx_i       <= '0;
            idx_j       <= '0;
            product_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Two's-complement negation of the most negative value gives 2^(WIDTH-1), which still fits as an unsigned magnitude.
                        a_mag   <= (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
                        b_mag   <= (signed_mode && datab[WIDTH-1]) ? -datab : datab;
                        neg_res <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
                        acc     <= '0;
                        idx_i   <= '0;
                        idx_j   <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_pair) begin
                        idx_i       <= '0;
                        idx_j       <= '0;
                        state       <= DONE;
                        product_out <= neg_res ? -acc_next : acc_next;
                    end else if (idx_j == LAST_IDX) begin
                        idx_j <= '0;
                        idx_i <= idx_i + IDX_W'(1);
                    end else begin
                        idx_j <= idx_j + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == CALC);
    assign done_flag = (state == DONE);
    assign state_out = state;

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Bench for seq_mult_nxn at 8/4, 16/4 and 16/8. Results are compared with a plain-arithmetic
// signed/unsigned product, and the timing of busy and done_flag is checked for each operation.
module tb_seq_mult_nxn;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a;
    logic        sm;
    logic [2:0]  start_v;
    logic [15:0] da, db;
    logic [2:0]  busy_v, done_v;
    logic [1:0]  st0, st1, st2;
    logic [15:0] p0;
    logic [31:0] p1, p2;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] last_prod [3];

    seq_mult_nxn #(.WIDTH(8), .DIGIT(4)) u_m8x4 (
        .clk(clk), .reset_a(reset_a), .start(start_v[0]), .signed_mode(sm),
        .dataa(da[7:0]), .datab(db[7:0]), .busy(busy_v[0]), .done_flag(done_v[0]),
        .product_out(p0), .state_out(st0));

    seq_mult_nxn #(.WIDTH(16), .DIGIT(4)) u_m16x4 (
        .clk(clk), .reset_a(reset_a), .start(start_v[1]), .signed_mode(sm),
        .dataa(da), .datab(db), .busy(busy_v[1]), .done_flag(done_v[1]),
        .product_out(p1), .state_out(st1));

    seq_mult_nxn #(.WIDTH(16), .DIGIT(8)) u_m16x8 (
        .clk(clk), .reset_a(reset_a), .start(start_v[2]), .signed_mode(sm),
        .dataa(da), .datab(db), .busy(busy_v[2]), .done_flag(done_v[2]),
        .product_out(p2), .state_out(st2));

    function automatic logic [31:0] prod_of(int sel);
        case (sel)
            0:       return 32'(p0);
            1:       return p1;
            default: return p2;
        endcase
    endfunction

    function automatic logic [31:0] st_of(int sel);
        case (sel)
            0:       return 32'(st0);
            1:       return 32'(st1);
            default: return 32'(st2);
        endcase
    endfunction

    function automatic int w_of(int sel);
        return (sel == 0) ? 8 : 16;
    endfunction

    function automatic int lat_of(int sel);
        return (sel == 1) ? 16 : 4;
    endfunction

    // Reference: interpret operands as w-bit numbers, multiply, keep 2w bits.
    function automatic logic [31:0] ref_prod(int w, logic [15:0] a, logic [15:0] b, bit s);
        longint mask, av, bv;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && (((av >> (w - 1)) & 1) != 0)) av = av - (longint'(1) << w);
        if (s && (((bv >> (w - 1)) & 1) != 0)) bv = bv - (longint'(1) << w);
        return 32'((av * bv) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input logic [31:0] exp, input bit hold, input bit scramble);
        int lat, busy_cnt, done_cnt;
        lat      = lat_of(sel);
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        da = a;
        db = b;
        sm = s;
        start_v = 3'b000;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_v = 3'b000;
        for (int k = 1; k <= lat; k++) begin
            busy_cnt += int'(busy_v[sel]);
            done_cnt += int'(done_v[sel]);
            if (k == lat) chk($sformatf("d%0d_prod_hold", sel), prod_of(sel), last_prod[sel]);
            if (scramble) begin
                da = 16'($urandom);
                db = 16'($urandom);
                sm = ~sm;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("d%0d_busy_len", sel), 32'(busy_cnt), 32'(lat));
        chk($sformatf("d%0d_done_early", sel), 32'(done_cnt), 32'd0);
        chk($sformatf("d%0d_done", sel), 32'(done_v[sel]), 32'd1);
        chk($sformatf("d%0d_busy_in_done", sel), 32'(busy_v[sel]), 32'd0);
        chk($sformatf("d%0d_state_done", sel), st_of(sel), 32'd2);
        chk($sformatf("d%0d_prod a=%0h b=%0h s=%0d", sel, a, b, s), prod_of(sel), exp);
        last_prod[sel] = exp;
        @(posedge clk); #1;
        chk($sformatf("d%0d_done_width", sel), 32'(done_v[sel]), 32'd0);
        chk($sformatf("d%0d_state_idle", sel), st_of(sel), 32'd0);
        start_v = 3'b000;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb, mask;
        int sel;
        int dcnt;
        reset_a = 1'b1;
        start_v = 3'b000;
        sm = 1'b0;
        da = '0;
        db = '0;
        for (int i = 0; i < 3; i++) last_prod[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_state", i), st_of(i), 32'd0);
            chk($sformatf("d%0d_rst_prod", i), prod_of(i), 32'd0);
        end
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        @(negedge clk);
        reset_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_stay_busy", 32'(busy_v), 32'd0);

        // Directed cases for 8/4 and 16/4.
        do_op(0, 16'd10, 16'd20, 1'b0, 32'h00C8, 1'b0, 1'b0);
        do_op(0, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01, 1'b0, 1'b0);
        do_op(0, 16'h0080, 16'h0080, 1'b1, 32'h4000, 1'b0, 1'b0);
        do_op(0, 16'h00FD, 16'h0005, 1'b1, 32'hFFF1, 1'b0, 1'b0);
        do_op(0, 16'h0000, 16'h00FF, 1'b1, 32'h0000, 1'b0, 1'b0);
        do_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0);
        do_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0, 1'b0);
        do_op(1, 16'h8000, 16'h7FFF, 1'b1, ref_prod(16, 16'h8000, 16'h7FFF, 1'b1), 1'b0, 1'b0);

        // Start held high with operands scrambled during CALC, followed by a back-to-back start.
        do_op(0, 16'h0033, 16'h00C4, 1'b0, ref_prod(8, 16'h0033, 16'h00C4, 1'b0), 1'b1, 1'b1);
        do_op(0, 16'h0081, 16'h007F, 1'b1, ref_prod(8, 16'h0081, 16'h007F, 1'b1), 1'b1, 1'b1);
        do_op(1, 16'hA5A5, 16'h5A5A, 1'b1, ref_prod(16, 16'hA5A5, 16'h5A5A, 1'b1), 1'b1, 1'b1);

        // Reset asserted in the second CALC cycle.
        @(negedge clk);
        da = 16'd100;
        db = 16'd100;
        sm = 1'b0;
        start_v = 3'b001;
        @(posedge clk); #1;
        start_v = 3'b000;
        @(posedge clk); #1;
        reset_a = 1'b1;
        @(posedge clk); #1;
        chk("midcalc_rst_state", st_of(0), 32'd0);
        chk("midcalc_rst_prod", prod_of(0), 32'd0);
        chk("midcalc_rst_done", 32'(done_v[0]), 32'd0);
        chk("midcalc_rst_busy", 32'(busy_v[0]), 32'd0);
        for (int i = 0; i < 3; i++) last_prod[i] = '0;
        @(negedge clk);
        reset_a = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            dcnt += int'(done_v[0]);
        end
        chk("midcalc_no_done", 32'(dcnt), 32'd0);
        do_op(0, 16'd7, 16'd9, 1'b0, 32'h003F, 1'b0, 1'b0);

        // A start presented on the same edge as reset is discarded.
        @(negedge clk);
        reset_a = 1'b1;
        start_v = 3'b111;
        da = 16'd5;
        db = 16'd5;
        @(posedge clk); #1;
        @(negedge clk);
        reset_a = 1'b0;
        start_v = 3'b000;
        @(posedge clk); #1;
        chk("rst_start_busy", 32'(busy_v), 32'd0);
        chk("rst_start_state0", st_of(0), 32'd0);
        for (int i = 0; i < 3; i++) last_prod[i] = '0;

        // Reset asserted while in DONE.
        @(negedge clk);
        da = 16'd12;
        db = 16'd13;
        start_v = 3'b001;
        @(posedge clk); #1;
        start_v = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_done", 32'(done_v[0]), 32'd1);
        chk("pre_rst_prod", prod_of(0), 32'd156);
        reset_a = 1'b1;
        @(posedge clk); #1;
        chk("done_rst_prod", prod_of(0), 32'd0);
        chk("done_rst_state", st_of(0), 32'd0);
        chk("done_rst_flag", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        reset_a = 1'b0;

        // Random operands for 8/4 and 16/8 in both modes, plus a few on 16/4.
        for (int c = 0; c < 2; c++) begin
            sel = (c == 0) ? 0 : 2;
            mask = (w_of(sel) == 8) ? 16'h00FF : 16'hFFFF;
            for (int m = 0; m < 2; m++) begin
                for (int n = 0; n < 1000; n++) begin
                    ra = 16'($urandom) & mask;
                    rb = 16'($urandom) & mask;
                    do_op(sel, ra, rb, m[0], ref_prod(w_of(sel), ra, rb, m[0]), 1'b0, n[0]);
                end
            end
        end
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op(1, ra, rb, n[0], ref_prod(16, ra, rb, n[0]), 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
